// File: rtl/fp_operand_assembler.sv
// Byte-serial operand assembler: packs DATA_W-bit bytes into NUM_WORDS words and
// hands complete bundles downstream, with one extra bundle held while stalled.
module fp_operand_assembler #(
  parameter int DATA_W         = 8,
  parameter int BYTES_PER_WORD = 4,
  parameter int NUM_WORDS      = 2,
  parameter int MSB_FIRST      = 1
) (
  input  logic                                         clk,
  input  logic                                         reset,
  input  logic [DATA_W-1:0]                            din,
  input  logic                                         din_valid,
  output logic                                         in_ready,
  input  logic                                         frame_clr,
  output logic [NUM_WORDS*BYTES_PER_WORD*DATA_W-1:0]   operands,
  output logic                                         out_valid,
  input  logic                                         out_ready,
  output logic [$clog2(NUM_WORDS*BYTES_PER_WORD+1)-1:0] byte_cnt,
  output logic                                         overrun
);

  localparam int W     = DATA_W * BYTES_PER_WORD;
  localparam int TOTAL = NUM_WORDS * BYTES_PER_WORD;
  localparam int OPW   = NUM_WORDS * W;
  localparam int CW    = $clog2(TOTAL + 1);
  localparam logic [CW-1:0] LAST = CW'(TOTAL - 1);

  // Handshakes: a byte moves when din_valid && in_ready; a bundle moves when
  // out_valid && out_ready. Neither ready depends on its own valid.

  logic [OPW-1:0] collect;
  logic [OPW-1:0] coll_ins;
  logic           pending;
  logic           accept;
  logic           last_byte;
  logic           slot_free;

  // Bit offset of frame byte i inside the bundle; word 0 sits at the top.
  function automatic int byte_off(input int i);
    int k;
    int p;
    int lane;
    k    = i / BYTES_PER_WORD;
    p    = i % BYTES_PER_WORD;
    lane = (MSB_FIRST != 0) ? (BYTES_PER_WORD - 1 - p) : p;
    return (NUM_WORDS - 1 - k) * W + lane * DATA_W;
  endfunction

  assign in_ready  = !pending;
  assign accept    = din_valid && in_ready && !frame_clr;
  assign last_byte = (byte_cnt == LAST);
  assign slot_free = !out_valid || out_ready;

  always_comb begin
    coll_ins = collect;
    for (int i = 0; i < TOTAL; i++) begin
      if (byte_cnt == CW'(i)) coll_ins[byte_off(i) +: DATA_W] = din;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      operands  <= '0;
      out_valid <= 1'b0;
      byte_cnt  <= '0;
      overrun   <= 1'b0;
      pending   <= 1'b0;
      collect   <= '0;
    end else begin
      if (out_valid && out_ready) out_valid <= 1'b0;
      if (frame_clr) begin
        byte_cnt <= '0;
        pending  <= 1'b0;
        overrun  <= 1'b0;
        collect  <= '0;
      end else begin
        if (pending && out_ready) begin
          operands  <= collect;
          out_valid <= 1'b1;
          pending   <= 1'b0;
        end
        if (accept) begin
          collect <= coll_ins;
          if (last_byte) begin
            byte_cnt <= '0;
            // A free slot takes the bundle directly; otherwise park it.
            if (slot_free) begin
              operands  <= coll_ins;
              out_valid <= 1'b1;
            end else begin
              pending <= 1'b1;
            end
          end else begin
            byte_cnt <= byte_cnt + CW'(1);
          end
        end else if (din_valid) begin
          overrun <= 1'b1;
        end
      end
    end
  end

endmodule
